// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
//   Shared constants, per-bit state encoding and the counter-width helper for
//   the switch/button debouncer (sw_debounce and its per-bit slice
//   debounce_bit).
//
//   Optional feature macro: SW_DEBOUNCE_TOGGLE_EN (adds press-to-toggle
//   outputs in debounce_bit and sw_debounce).
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

    // Default build constants for the buttons board.
    localparam int SW_WIDTH         = 8;
    localparam int SW_SYNC_STAGES   = 2;
    localparam int SW_STABLE_CYCLES = 1000;

    // Per-bit qualification state: IDLE while the counter is zero, QUAL while a
    // candidate level change is being counted.
    typedef enum logic [0:0] {
        DB_IDLE = 1'b0,
        DB_QUAL = 1'b1
    } db_state_e;

    // Counter width able to hold 0 .. stable-1 with one bit of headroom, so the
    // width stays at least 1 even for stable == 1.
    function automatic int cnt_width(input int stable);
        return $clog2(stable) + 1;
    endfunction

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   One switch bit: metastability synchroniser, stability counter, debounced
//   level and one-cycle rise/fall pulses. With SW_DEBOUNCE_TOGGLE_EN defined
//   it also keeps a toggle flop that flips on every accepted rising edge.
//
// Parameters
//   SYNC_STAGES    flops in the synchroniser chain (>= 2)
//   STABLE_CYCLES  consecutive mismatching synchronised samples needed to
//                  accept a new level (>= 1)
//
// Ports
//   clk       in   clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   sw_i      in   raw asynchronous switch level
//   sw_o      out  debounced level (registered)
//   rise_o    out  one-cycle pulse when sw_o goes 0->1 (registered)
//   fall_o    out  one-cycle pulse when sw_o goes 1->0 (registered)
//   busy_o    out  high while a change is being qualified (counter non-zero)
//   toggle_o  out  (SW_DEBOUNCE_TOGGLE_EN only) flips on every rise_o
// -----------------------------------------------------------------------------
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = SW_SYNC_STAGES,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic toggle_o,
`endif
    output logic busy_o
);

    localparam int              CW        = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_s;
    logic                   diff_s;
    logic                   last_s;

    db_state_e              state_q;
    db_state_e              state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic                   toggle_q;
    logic                   toggle_d;
`endif

    // Synchroniser shift: new raw sample enters at bit 0, the settled value
    // leaves at the top bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_i};
    end

    assign s_s    = sync_q[SYNC_STAGES-1];
    assign diff_s = s_s ^ level_q;
    // For STABLE_CYCLES == 1 the last count is zero, so a mismatch seen in
    // IDLE is accepted straight away and QUAL is never entered.
    assign last_s = (cnt_q == CNT_LAST);

    // Qualification state machine: count consecutive mismatches, drop all
    // progress on any matching sample, accept the new level on the last count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (diff_s) begin
                    if (last_s) begin
                        level_d = s_s;
                        rise_d  = s_s;
                        fall_d  = ~s_s;
                        cnt_d   = CNT_ZERO;
                        state_d = DB_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = DB_QUAL;
                    end
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = DB_IDLE;
                end
            end
            DB_QUAL: begin
                if (!diff_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = DB_IDLE;
                end else if (last_s) begin
                    level_d = s_s;
                    rise_d  = s_s;
                    fall_d  = ~s_s;
                    cnt_d   = CNT_ZERO;
                    state_d = DB_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = DB_QUAL;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = DB_IDLE;
            end
        endcase
    end

`ifdef SW_DEBOUNCE_TOGGLE_EN
    // Toggle flips in the same cycle the rise pulse is registered.
    always_comb begin
        toggle_d = toggle_q ^ rise_d;
    end
`endif

    // State registers; the reset edge clears everything and emits no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            state_q  <= DB_IDLE;
            cnt_q    <= CNT_ZERO;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
            toggle_q <= 1'b0;
`endif
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
`ifdef SW_DEBOUNCE_TOGGLE_EN
            toggle_q <= toggle_d;
`endif
        end
    end

    assign sw_o     = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign busy_o   = (cnt_q != CNT_ZERO);
`ifdef SW_DEBOUNCE_TOGGLE_EN
    assign toggle_o = toggle_q;
`endif

endmodule : debounce_bit

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Per-bit synchroniser and debouncer between the switch input buffers and
//   the LED output buffers. Each bit is an independent debounce_bit; the top
//   only replicates the slice and ORs the per-bit busy flags.
//
//   Optional feature macro: SW_DEBOUNCE_TOGGLE_EN adds toggle_o.
//
// Parameters
//   WIDTH          number of independent input bits
//   SYNC_STAGES    metastability flops per bit (>= 2)
//   STABLE_CYCLES  consecutive mismatching cycles to accept a new level (>= 1)
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   sw_i      in   [WIDTH] raw switch/button levels
//   sw_o      out  [WIDTH] debounced levels (registered)
//   rise_o    out  [WIDTH] one-cycle 0->1 pulses
//   fall_o    out  [WIDTH] one-cycle 1->0 pulses
//   busy_o    out  any bit currently qualifying a change
//   toggle_o  out  [WIDTH] (SW_DEBOUNCE_TOGGLE_EN only) press-to-toggle level
// -----------------------------------------------------------------------------
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int SYNC_STAGES   = SW_SYNC_STAGES,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic [WIDTH-1:0] toggle_o,
`endif
    output logic             busy_o
);

    logic [WIDTH-1:0] busy_bits_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_i     (sw_i[g]),
            .sw_o     (sw_o[g]),
            .rise_o   (rise_o[g]),
            .fall_o   (fall_o[g]),
`ifdef SW_DEBOUNCE_TOGGLE_EN
            .toggle_o (toggle_o[g]),
`endif
            .busy_o   (busy_bits_s[g])
        );
    end

    assign busy_o = |busy_bits_s;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//   Self-checking bench for sw_debounce (WIDTH=8, SYNC_STAGES=2,
//   STABLE_CYCLES=4). A reference model keeps the history of sampled inputs and
//   declares a level change when the STABLE most recent synchronised samples
//   all differ from the current output. Directed steps plus a random phase.
//   Honours SW_DEBOUNCE_TOGGLE_EN.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int W  = 8;
    localparam int SY = 2;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw_i;
    logic [W-1:0] sw_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         busy_o;
`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [W-1:0] toggle_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH         (W),
        .SYNC_STAGES   (SY),
        .STABLE_CYCLES (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_i     (sw_i),
        .sw_o     (sw_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
`ifdef SW_DEBOUNCE_TOGGLE_EN
        .toggle_o (toggle_o),
`endif
        .busy_o   (busy_o)
    );

    // ---------------- reference model ----------------
    // hist[0] is the sample taken at the latest edge; the value acted upon at
    // that edge is hist[SY] (the sample taken SY edges earlier).
    logic [W-1:0] hist [SY+ST];
    logic [W-1:0] m_out  = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic [W-1:0] m_tog  = '0;
    logic         m_busy = 1'b0;
    logic [W-1:0] all_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SY + ST; i++) hist[i] = '0;
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            m_tog  = '0;
            m_busy = 1'b0;
        end else begin
            for (int i = SY + ST - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sw_i;
            all_diff = '1;
            for (int j = 0; j < ST; j++) all_diff = all_diff & (hist[SY+j] ^ m_out);
            m_rise = all_diff & ~m_out;
            m_fall = all_diff & m_out;
            m_out  = m_out ^ all_diff;
            m_tog  = m_tog ^ m_rise;
            m_busy = |(hist[SY] ^ m_out);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; after each, compare every output with the model.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("model_sw",   sw_o,   m_out);
            chk("model_rise", rise_o, m_rise);
            chk("model_fall", fall_o, m_fall);
            chk("model_busy", {7'd0, busy_o}, {7'd0, m_busy});
`ifdef SW_DEBOUNCE_TOGGLE_EN
            chk("model_tog",  toggle_o, m_tog);
`endif
        end
    endtask

    logic [W-1:0] pulse_seen;
    int           idx;

    initial begin
        sw_i  = 8'hFF;
        rst_n = 1'b0;

        // 1. reset, then release with all inputs high
        step(3);
        chk("rst_sw",   sw_o,   8'h00);
        chk("rst_rise", rise_o, 8'h00);
        chk("rst_fall", fall_o, 8'h00);
        chk("rst_busy", {7'd0, busy_o}, 8'h00);
        rst_n = 1'b1;
        step(5);
        chk("t1_sw_pre", sw_o, 8'h00);
        step(1);
        chk("t1_sw",   sw_o,   8'hFF);
        chk("t1_rise", rise_o, 8'hFF);
        step(1);
        chk("t1_rise_off", rise_o, 8'h00);

        // 2. single-bit step on bit 0
        sw_i = 8'h00;
        step(10);
        chk("t2_base", sw_o, 8'h00);
        sw_i = 8'h01;
        step(2);
        chk("t2_busy_e2", {7'd0, busy_o}, 8'h00);
        step(1);
        chk("t2_busy_e3", {7'd0, busy_o}, 8'h01);
        step(2);
        chk("t2_busy_e5", {7'd0, busy_o}, 8'h01);
        chk("t2_sw_e5",   sw_o, 8'h00);
        step(1);
        chk("t2_sw_e6",   sw_o,   8'h01);
        chk("t2_rise_e6", rise_o, 8'h01);
        chk("t2_busy_e6", {7'd0, busy_o}, 8'h00);
        step(1);
        chk("t2_rise_e7", rise_o, 8'h00);

        // 3. three-cycle glitch on bit 3
        pulse_seen = '0;
        sw_i = 8'h09;
        for (int k = 0; k < 3; k++) begin
            step(1);
            pulse_seen = pulse_seen | rise_o | fall_o;
        end
        sw_i = 8'h01;
        for (int k = 0; k < 6; k++) begin
            step(1);
            pulse_seen = pulse_seen | rise_o | fall_o;
        end
        chk("t3_sw",     sw_o, 8'h01);
        chk("t3_pulses", pulse_seen, 8'h00);
        chk("t3_busy",   {7'd0, busy_o}, 8'h00);

        // 4. several bits together
        sw_i = 8'h00;
        step(10);
        sw_i = 8'hA5;
        step(5);
        chk("t4_rise_pre", rise_o, 8'h00);
        step(1);
        chk("t4_rise", rise_o, 8'hA5);
        chk("t4_sw",   sw_o,   8'hA5);
        step(1);
        chk("t4_rise_off", rise_o, 8'h00);
        step(8);
        sw_i = 8'h00;
        step(5);
        chk("t4_fall_pre", fall_o, 8'h00);
        step(1);
        chk("t4_fall",     fall_o, 8'hA5);
        chk("t4_fall_rise", rise_o, 8'h00);
        step(1);
        chk("t4_fall_off", fall_o, 8'h00);

        // 5. reset in the middle of qualification
        sw_i = 8'h80;
        step(4);
        chk("t5_busy_mid", {7'd0, busy_o}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {7'd0, busy_o}, 8'h00);
        chk("t5_rst_sw",   sw_o, 8'h00);
        step(2);
        chk("t5_rst_rise", rise_o, 8'h00);
        rst_n = 1'b1;
        step(5);
        chk("t5_rise_pre", rise_o, 8'h00);
        step(1);
        chk("t5_rise", rise_o, 8'h80);
        chk("t5_sw",   sw_o,   8'h80);
        step(1);

        // 6. clean presses on bit 1 from a fresh reset
        sw_i  = 8'h00;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(4);
        for (int p = 0; p < 3; p++) begin
            sw_i = 8'h02;
            step(8);
            chk("t6_sw_press", sw_o, 8'h02);
`ifdef SW_DEBOUNCE_TOGGLE_EN
            chk("t6_toggle", toggle_o, (p % 2 == 0) ? 8'h02 : 8'h00);
`endif
            sw_i = 8'h00;
            step(8);
            chk("t6_sw_release", sw_o, 8'h00);
        end

        // random phase against the model, with one reset pulse mid-way
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, W - 1);
                sw_i[idx] = ~sw_i[idx];
            end
            if ($urandom_range(0, 99) == 0) sw_i = W'($urandom);
            if (c == 1500) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sw_debounce
